mux_sel_arbiter: RTL and testbench
==================================

MUX_SEL_ARBITER -- requirements
Module: mux_sel_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, sets the maximum consecutive grant cycles per channel while others wait; legal range 1..15.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  request per mux input; bit i requests mux input Ai.
REQ-005 gnt  output 4  one-hot grant; bit i set when Ai is selected; all-zero when idle.
REQ-006 sel  output 2  select code driven to the 4x1 mux sel port; equals index of the set gnt bit.
REQ-007 valid output 1  high when gnt is non-zero, i.e. sel currently designates a granted input.

Function
REQ-008 The block SHALL be the upstream select generator for the 4x1 mux: sel=i routes Ai to y.
REQ-009 States: IDLE (no grant) and GRANT (one channel granted).
REQ-010 All outputs SHALL be registered; grant latency from req assertion to gnt/valid SHALL be one clock.
REQ-011 Round-robin pointer ptr (2 bits) SHALL hold last-granted index + 1 mod 4; search order ptr, ptr+1, ptr+2, ptr+3 (wrap 3->0).
REQ-012 IDLE: if req == 0, stay IDLE with gnt=0, valid=0, sel holding its last value; else go to GRANT on the first requesting channel in search order.
REQ-013 On every new grant: gnt one-hot at chosen index, sel=index, valid=1, ptr=index+1 mod 4, hold_cnt=1.
REQ-014 GRANT, req[sel]=0: release the same edge; if any other req set, grant next in search order with no idle cycle; else go to IDLE (gnt=0, valid=0).
REQ-015 GRANT, req[sel]=1 and hold_cnt < MAX_HOLD: keep grant, hold_cnt increments.
REQ-016 GRANT, req[sel]=1, hold_cnt == MAX_HOLD, another req set: rotate to next requester in search order.
REQ-017 GRANT, req[sel]=1, hold_cnt == MAX_HOLD, no other req: keep grant, hold_cnt reloads to 1.
REQ-018 Simultaneous requests SHALL be resolved solely by ptr; no fixed priority.
REQ-019 gnt SHALL never have more than one bit set; sel and gnt SHALL always agree while valid=1.
REQ-020 hold_cnt width SHALL be 4 bits and SHALL never exceed MAX_HOLD.

Reset
REQ-021 rst=1 SHALL immediately force state=IDLE, gnt=0, valid=0, sel=0, ptr=0, hold_cnt=0, independent of clk.
REQ-022 Reset asserted mid-grant SHALL drop the grant without completing the hold; after release, the first grant searches from channel 0.
REQ-023 First clock edge after rst deassertion SHALL evaluate req normally.

Structure
REQ-024 Shared package mux_arb_pkg SHALL hold NUM_CH=4, SEL_W=2, the state enumeration (IDLE, GRANT), and the MAX_HOLD default.
REQ-025 One combinational sub-module rr_pick SHALL compute the next index and a found flag from req, ptr and an exclude mask.
REQ-026 The arbiter top SHALL contain only the state register, ptr, hold_cnt and output registers.

Verification
REQ-027 Reset then req=4'b0100 -> one clock later gnt=4'b0100, sel=2, valid=1; ptr=3.
REQ-028 From reset, req=4'b1111 held, MAX_HOLD=4 -> sel sequence 0,0,0,0,1,1,1,1,2,2,2,2,3,3,3,3,0 with no idle gaps.
REQ-029 Grant on sel=1, req drops to 4'b1000 -> next clock sel=3, valid=1; then req=0 -> next clock valid=0, gnt=0, sel stays 3.
REQ-030 Only req[2] held for 10 cycles, MAX_HOLD=4 -> gnt=4'b0100 continuously, hold_cnt cycles 1..4,1..4,1,2.
REQ-031 rst pulsed asynchronously between edges while sel=3 granted -> gnt=0, valid=0, sel=0 before next edge; after release with req=4'b1010 -> sel=1.
REQ-032 Random req for 2000 cycles -> gnt always one-hot or zero, sel matches gnt, no waiting requester starved beyond 3*MAX_HOLD cycles.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared constants, state encoding and helpers for the round-robin mux select arbiter.
package mux_arb_pkg;
    localparam int NUM_CH       = 4;
    localparam int SEL_W        = 2;
    localparam int HOLD_W       = 4;
    localparam int MAX_HOLD_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    function automatic logic [NUM_CH-1:0] sel2onehot(input logic [SEL_W-1:0] s);
        return NUM_CH'(1) << s;
    endfunction
endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requester at or after ptr, skipping excluded channels.
module rr_pick
    import mux_arb_pkg::*;
(
    input  logic [NUM_CH-1:0] i_req,
    input  logic [SEL_W-1:0]  i_ptr,
    input  logic [NUM_CH-1:0] i_excl,
    output logic [SEL_W-1:0]  o_idx,
    output logic              o_found
);
    logic [NUM_CH-1:0] w_cand;

    assign w_cand = i_req & ~i_excl;

    // Walk the order backwards so the candidate closest to ptr is written last and wins.
    always_comb begin
        logic [SEL_W-1:0] w_pos;
        o_idx   = '0;
        o_found = 1'b0;
        w_pos   = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_pos = i_ptr + SEL_W'(k);
            if (w_cand[w_pos]) begin
                o_idx   = w_pos;
                o_found = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mux_sel_arbiter.sv
// Round-robin select generator for a 4x1 mux with a bounded per-channel hold time.
module mux_sel_arbiter
    import mux_arb_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    output logic [NUM_CH-1:0] gnt,
    output logic [SEL_W-1:0]  sel,
    output logic              valid
);
    arb_state_t        r_state;
    logic [NUM_CH-1:0] r_gnt;
    logic [SEL_W-1:0]  r_sel;
    logic              r_valid;
    logic [SEL_W-1:0]  r_ptr;
    logic [HOLD_W-1:0] r_hold_cnt;

    arb_state_t        w_state_next;
    logic [NUM_CH-1:0] w_gnt_next;
    logic [SEL_W-1:0]  w_sel_next;
    logic              w_valid_next;
    logic [SEL_W-1:0]  w_ptr_next;
    logic [HOLD_W-1:0] w_hold_cnt_next;

    logic              w_take;
    logic              w_hold_inc;
    logic              w_hold_reload;
    logic [NUM_CH-1:0] w_excl;
    logic [SEL_W-1:0]  w_idx;
    logic              w_found;

    // While granted, ptr already sits just past sel, so excluding sel leaves only other channels.
    assign w_excl = (r_state == GRANT) ? sel2onehot(r_sel) : '0;

    rr_pick u_rr_pick (
        .i_req   (req),
        .i_ptr   (r_ptr),
        .i_excl  (w_excl),
        .o_idx   (w_idx),
        .o_found (w_found)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_gnt      <= '0;
            r_sel      <= '0;
            r_valid    <= 1'b0;
            r_ptr      <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_state_next;
            r_gnt      <= w_gnt_next;
            r_sel      <= w_sel_next;
            r_valid    <= w_valid_next;
            r_ptr      <= w_ptr_next;
            r_hold_cnt <= w_hold_cnt_next;
        end
    end

    always_comb begin
        w_state_next  = r_state;
        w_take        = 1'b0;
        w_hold_inc    = 1'b0;
        w_hold_reload = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_found) begin
                    w_state_next = GRANT;
                    w_take       = 1'b1;
                end
            end
            GRANT: begin
                if (!req[r_sel]) begin
                    if (w_found) w_take = 1'b1;
                    else         w_state_next = IDLE;
                end else if (r_hold_cnt < HOLD_W'(MAX_HOLD)) begin
                    w_hold_inc = 1'b1;
                end else if (w_found) begin
                    w_take = 1'b1;
                end else begin
                    w_hold_reload = 1'b1;
                end
            end
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        w_gnt_next      = r_gnt;
        w_sel_next      = r_sel;
        w_valid_next    = r_valid;
        w_ptr_next      = r_ptr;
        w_hold_cnt_next = r_hold_cnt;
        if (w_take) begin
            w_gnt_next      = sel2onehot(w_idx);
            w_sel_next      = w_idx;
            w_valid_next    = 1'b1;
            w_ptr_next      = w_idx + SEL_W'(1);
            w_hold_cnt_next = HOLD_W'(1);
        end else if (w_hold_inc) begin
            w_hold_cnt_next = r_hold_cnt + HOLD_W'(1);
        end else if (w_hold_reload) begin
            w_hold_cnt_next = HOLD_W'(1);
        end else if (w_state_next == IDLE) begin
            w_gnt_next   = '0;
            w_valid_next = 1'b0;
        end
    end

    assign gnt   = r_gnt;
    assign sel   = r_sel;
    assign valid = r_valid;
endmodule

// File: tb/tb_mux_sel_arbiter.sv
// Directed and randomized checks of mux_sel_arbiter against a queue-free behavioural model.
module tb_mux_sel_arbiter;
    localparam int MAXH = 4;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] gnt;
    logic [1:0] sel;
    logic       valid;

    int checks = 0;
    int errors = 0;

    // Behavioural model state: which channel owns the mux (or none), and how long it has held it.
    int m_owner;
    int m_sel;
    int m_ptr;
    int m_hold;
    int m_wait [4];

    mux_sel_arbiter #(.MAX_HOLD(MAXH)) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .gnt   (gnt),
        .sel   (sel),
        .valid (valid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_owner = -1;
        m_sel   = 0;
        m_ptr   = 0;
        m_hold  = 0;
        foreach (m_wait[i]) m_wait[i] = 0;
    endtask

    function automatic int first_in_order(input logic [3:0] rq, input int skip);
        for (int k = 0; k < 4; k++) begin
            int c;
            c = (m_ptr + k) % 4;
            if (rq[c] && c != skip) return c;
        end
        return -1;
    endfunction

    task automatic model_step(input logic [3:0] rq);
        int nxt;
        if (m_owner < 0) begin
            nxt = first_in_order(rq, -1);
        end else if (!rq[m_owner] || m_hold == MAXH) begin
            nxt = first_in_order(rq, m_owner);
            if (nxt < 0) begin
                if (!rq[m_owner]) m_owner = -1;
                else              m_hold = 1;
            end
        end else begin
            nxt = -1;
            m_hold = m_hold + 1;
        end
        if (nxt >= 0) begin
            m_owner = nxt;
            m_sel   = nxt;
            m_ptr   = (nxt + 1) % 4;
            m_hold  = 1;
        end
        for (int i = 0; i < 4; i++)
            m_wait[i] = (rq[i] && m_owner != i) ? m_wait[i] + 1 : 0;
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] exp_gnt;
        exp_gnt = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
        check({tag, ".gnt"},   32'(gnt),   32'(exp_gnt));
        check({tag, ".sel"},   32'(sel),   32'(m_sel));
        check({tag, ".valid"}, 32'(valid), 32'(m_owner >= 0));
    endtask

    task automatic step(input logic [3:0] rq, input string tag);
        req = rq;
        @(posedge clk);
        #1;
        model_step(rq);
        check_outputs(tag);
    endtask

    // Pulse reset between edges and verify outputs clear before the next edge.
    task automatic do_reset(input logic [3:0] rq_after);
        req = 4'b0000;
        rst = 1'b1;
        #2;
        check("rst.gnt",   32'(gnt),   32'h0);
        check("rst.sel",   32'(sel),   32'h0);
        check("rst.valid", 32'(valid), 32'h0);
        check("rst.ptr",   32'(dut.r_ptr), 32'h0);
        rst = 1'b0;
        req = rq_after;
        model_reset();
    endtask

    initial begin
        int max_wait;
        logic [3:0] rq;
        rst = 1'b1;
        req = 4'b0000;
        model_reset();
        repeat (2) @(posedge clk);
        #1;

        // Single request on channel 2
        do_reset(4'b0100);
        step(4'b0100, "single");
        check("single.gnt_lit", 32'(gnt), 32'h4);
        check("single.ptr", 32'(dut.r_ptr), 32'd3);

        // All requesting: each channel holds MAXH cycles in turn
        do_reset(4'b1111);
        for (int k = 0; k < 17; k++) begin
            step(4'b1111, "all");
            check("all.seq", 32'(sel), 32'((k / MAXH) % 4));
            check("all.valid_lit", 32'(valid), 32'd1);
        end

        // Release hand-off to channel 3, then idle keeps sel
        do_reset(4'b0010);
        step(4'b0010, "drop.a");
        step(4'b1000, "drop.b");
        check("drop.sel3", 32'(sel), 32'd3);
        step(4'b0000, "drop.c");
        check("drop.idle_sel", 32'(sel), 32'd3);
        check("drop.idle_valid", 32'(valid), 32'd0);

        // Lone requester: hold counter wraps 1..MAXH
        do_reset(4'b0100);
        for (int k = 0; k < 10; k++) begin
            step(4'b0100, "lone");
            check("lone.hold", 32'(dut.r_hold_cnt), 32'((k % MAXH) + 1));
        end

        // Async reset mid-grant on channel 3, then restart from channel 0
        do_reset(4'b1000);
        step(4'b1000, "mid.a");
        step(4'b1000, "mid.b");
        do_reset(4'b1010);
        step(4'b1010, "mid.c");
        check("mid.sel1", 32'(sel), 32'd1);

        // Random sticky requests with starvation bound
        do_reset(4'b0000);
        rq = 4'b0000;
        for (int n = 0; n < 2000; n++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 3) == 0) rq[b] = ~rq[b];
            step(rq, "rand");
            max_wait = 0;
            foreach (m_wait[i]) if (m_wait[i] > max_wait) max_wait = m_wait[i];
            check("rand.starve", 32'(max_wait <= 3 * MAXH), 32'd1);
            check("rand.onehot", 32'($countones(gnt) <= 1), 32'd1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
